l2_tcdm_burst_reader: RTL and testbench
=======================================

// Module: l2_tcdm_burst_reader
// PURPOSE
//  TCDM initiator that fetches a block of consecutive words from L2 (interleaved or private bank)
//  and streams them out on a valid/ready port. Drives the same req/gnt/r_valid bus that the L2
//  banks answer, and is correct for any grant delay and any fixed or variable response latency.
//  Used by SoC-side loaders (boot copy, CFI metadata fetch) sitting on an XBAR_TCDM_BUS_CFI master port.
// PARAMETERS
//  DATA_WIDTH   32  word width; matches `CFI_INSTR_WIDTH_DEF in the SoC
//  ADDR_STRIDE  4   byte increment per word
//  FIFO_DEPTH   4   response buffer entries; also the maximum outstanding reads (power of 2, >=2)
//  LEN_WIDTH    16  width of the word-count field
// PORTS
//  clk_i           in   1           clock
//  rst_ni          in   1           async reset, active low
//  cmd_valid_i     in   1           command request
//  cmd_ready_o     out  1           command accepted when valid&ready
//  cmd_addr_i      in   32          byte start address
//  cmd_len_i       in   LEN_WIDTH   number of words
//  tcdm_req_o      out  1           TCDM request
//  tcdm_add_o      out  32          TCDM byte address
//  tcdm_wen_o      out  1           constant 1 (read)
//  tcdm_be_o       out  DATA_WIDTH/8  all ones
//  tcdm_wdata_o    out  DATA_WIDTH  constant 0
//  tcdm_gnt_i      in   1           grant
//  tcdm_r_valid_i  in   1           read data valid
//  tcdm_r_rdata_i  in   DATA_WIDTH  read data
//  data_valid_o    out  1           stream word available
//  data_ready_i    in   1           stream consumer ready
//  data_o          out  DATA_WIDTH  stream word (FIFO head)
//  busy_o          out  1           FSM not IDLE
//  done_o          out  1           1-cycle pulse on command completion
//  err_o           out  1           1-cycle pulse on rejected command (range check only)
// BEHAVIOUR
//  Reset: FSM=IDLE, tcdm_req_o=0, tcdm_add_o=0, data_valid_o=0, busy_o/done_o/err_o=0, FIFO empty, credits=0.
//   cmd_ready_o=1 out of reset.
//  FSM IDLE: cmd_ready_o=1. On accept, latch addr/len.
//   len==0 -> done_o pulses the next cycle; FSM stays IDLE.
//   len!=0 -> ISSUE.
//  FSM ISSUE: tcdm_req_o=1 only while credits < FIFO_DEPTH.
//   credits = granted-but-unpopped words (in flight + buffered).
//   Once raised, req and add stay stable until gnt (TCDM rule); req is never withdrawn without gnt.
//   On req&gnt: add += ADDR_STRIDE (mod 2^32, wraps silently), remaining--.
//   Last grant -> DRAIN; req drops the cycle after the last grant.
//  FSM DRAIN: wait for credits==0 (all words popped) -> done_o=1 for one cycle, go IDLE.
//  Credits: +1 on req&gnt, -1 on data_valid_o&data_ready_i. Both in the same cycle -> unchanged.
//  FIFO: push on tcdm_r_valid_i, pop on valid&ready. Push and pop together when full are legal.
//   Responses are in order; data_o = oldest word.
//   Overflow is impossible by the credit rule; r_valid while credits==0 is dropped.
//  Minimum latency: cmd accept -> req same+1 cycle.
//   With gnt=req and 1-cycle r_valid, the first data_valid_o is 3 cycles after accept.
//   Throughput is 1 word/cycle with data_ready_i held high.
//  Reset mid-operation: everything returns to reset values immediately; buffered data is lost.
// CONFIGURATION
//  L2_BURST_READER_RANGE_CHECK_EN defined:
//   - A command is accepted only if [addr, addr+len*ADDR_STRIDE) lies wholly inside
//     `SOC_MEM_MAP_TCDM_START_ADDR..END_ADDR or inside one private bank window.
//   - Otherwise err_o pulses one cycle after accept, no TCDM request is issued, and the FSM stays IDLE.
//  Not defined: no check; err_o is tied to 0; every address is issued.
// TESTING
//  1. Reset, cmd addr=0x1C00_0000 len=8, gnt=req, 1-cycle r_valid, ready=1 -> 8 reqs at +0x0..+0x1C;
//     data in order; one done_o pulse.
//  2. Stream ready=0 throughout, len=10, FIFO_DEPTH=4 -> exactly 4 grants then req=0.
//     Release ready -> remaining 6 words issued; no FIFO overflow.
//  3. Random gnt stall 0-5 cycles -> tcdm_add_o/req stable while gnt=0; words unique and in order.
//  4. len=0 -> no tcdm_req_o; done_o pulses 1 cycle after accept.
//  5. addr=0xFFFF_FFF8 len=4 (check off) -> addresses FFFF_FFF8, FFFF_FFFC, 0, 4.
//     With check on -> err_o pulse, no req.
//  6. Assert rst_ni mid-DRAIN -> all outputs at reset values same cycle; new command after release completes normally.

Source files
------------

// File: rtl/l2_tcdm_burst_reader.sv
// l2_tcdm_burst_reader: TCDM read initiator that fetches LEN consecutive words
// starting at a byte address and streams them out on a valid/ready port.
// Outstanding reads are limited by a credit counter so that every granted word
// always has a slot in the response FIFO, whatever the grant or response latency.
// Optional feature: define L2_BURST_READER_RANGE_CHECK_EN to reject commands whose
// burst does not lie wholly inside the interleaved L2 region or one private bank.
// Window bounds are treated as [START, END), END being the first byte past the window.

`ifdef L2_BURST_READER_RANGE_CHECK_EN
`ifndef SOC_MEM_MAP_TCDM_START_ADDR
`define SOC_MEM_MAP_TCDM_START_ADDR 32'h1C01_0000
`endif
`ifndef SOC_MEM_MAP_TCDM_END_ADDR
`define SOC_MEM_MAP_TCDM_END_ADDR 32'h1C08_0000
`endif
`ifndef SOC_MEM_MAP_PRIVATE_BANK0_START_ADDR
`define SOC_MEM_MAP_PRIVATE_BANK0_START_ADDR 32'h1C00_0000
`endif
`ifndef SOC_MEM_MAP_PRIVATE_BANK0_END_ADDR
`define SOC_MEM_MAP_PRIVATE_BANK0_END_ADDR 32'h1C00_8000
`endif
`ifndef SOC_MEM_MAP_PRIVATE_BANK1_START_ADDR
`define SOC_MEM_MAP_PRIVATE_BANK1_START_ADDR 32'h1C00_8000
`endif
`ifndef SOC_MEM_MAP_PRIVATE_BANK1_END_ADDR
`define SOC_MEM_MAP_PRIVATE_BANK1_END_ADDR 32'h1C01_0000
`endif
`endif

module l2_tcdm_burst_reader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_STRIDE = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int LEN_WIDTH   = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [31:0]             cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]    cmd_len_i,
   output logic                    tcdm_req_o,
   output logic [31:0]             tcdm_add_o,
   output logic                    tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
   output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
   input  logic                    tcdm_gnt_i,
   input  logic                    tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
   output logic                    data_valid_o,
   input  logic                    data_ready_i,
   output logic [DATA_WIDTH-1:0]   data_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [31:0]             addr_q;
   logic [LEN_WIDTH-1:0]    remaining_q;
   logic [CW-1:0]           credits_q;
   logic [CW-1:0]           count_q;
   logic [PW-1:0]           wr_ptr_q;
   logic [PW-1:0]           rd_ptr_q;
   logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic                    done_q;

   logic                    cmd_accept;
   logic                    len_zero;
   logic                    grant;
   logic                    push;
   logic                    pop;
   logic                    in_flight;
   logic                    range_ok;

   assign cmd_accept   = cmd_valid_i & cmd_ready_o;
   assign len_zero     = (cmd_len_i == '0);
   assign grant        = tcdm_req_o & tcdm_gnt_i;
   assign data_valid_o = (count_q != '0);
   assign pop          = data_valid_o & data_ready_i;
   // Credits cover buffered words too, so credits != count means a read is still in flight.
   assign in_flight    = (credits_q != count_q);
   assign push         = tcdm_r_valid_i & in_flight;
   assign data_o       = mem[rd_ptr_q];

   assign tcdm_add_o   = addr_q;
   assign tcdm_wen_o   = 1'b1;
   assign tcdm_be_o    = '1;
   assign tcdm_wdata_o = '0;
   assign done_o       = done_q;

`ifdef L2_BURST_READER_RANGE_CHECK_EN
   logic [63:0] cmd_start;
   logic [63:0] cmd_end;
   logic        in_tcdm;
   logic        in_bank0;
   logic        in_bank1;
   logic        err_q;

   assign cmd_start = {32'b0, cmd_addr_i};
   assign cmd_end   = cmd_start + (64'(cmd_len_i) * 64'(ADDR_STRIDE));
   assign in_tcdm   = (cmd_start >= 64'(`SOC_MEM_MAP_TCDM_START_ADDR)) &&
                      (cmd_end <= 64'(`SOC_MEM_MAP_TCDM_END_ADDR));
   assign in_bank0  = (cmd_start >= 64'(`SOC_MEM_MAP_PRIVATE_BANK0_START_ADDR)) &&
                      (cmd_end <= 64'(`SOC_MEM_MAP_PRIVATE_BANK0_END_ADDR));
   assign in_bank1  = (cmd_start >= 64'(`SOC_MEM_MAP_PRIVATE_BANK1_START_ADDR)) &&
                      (cmd_end <= 64'(`SOC_MEM_MAP_PRIVATE_BANK1_END_ADDR));
   assign range_ok  = in_tcdm | in_bank0 | in_bank1;
   assign err_o     = err_q;

   // Error pulse one cycle after accepting an out-of-range burst
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= cmd_accept & ~len_zero & ~range_ok;
      end
   end
`else
   assign range_ok = 1'b1;
   assign err_o    = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid_i && !len_zero && range_ok) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (grant && (remaining_q == LEN_WIDTH'(1))) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (credits_q == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; credits only fall while waiting for a grant, so req never drops before gnt
   always_comb begin
      cmd_ready_o = (state_q == IDLE);
      tcdm_req_o  = (state_q == ISSUE) && (credits_q < DEPTH_C);
      busy_o      = (state_q != IDLE);
   end

   // Address and remaining-word counters: load on accept, advance on each grant
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q      <= '0;
         remaining_q <= '0;
      end else if (cmd_accept) begin
         addr_q      <= cmd_addr_i;
         remaining_q <= cmd_len_i;
      end else if (grant) begin
         addr_q      <= addr_q + 32'(ADDR_STRIDE);
         remaining_q <= remaining_q - LEN_WIDTH'(1);
      end
   end

   // Credit counter: granted words not yet popped from the stream port
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credits_q <= '0;
      end else begin
         case ({grant, pop})
            2'b10:   credits_q <= credits_q + CW'(1);
            2'b01:   credits_q <= credits_q - CW'(1);
            default: credits_q <= credits_q;
         endcase
      end
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Response FIFO storage; contents are don't-care while empty
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr_q] <= tcdm_r_rdata_i;
      end
   end

   // Completion pulse: zero-length command, or drain finished with every word popped
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (cmd_accept & len_zero) | ((state_q == DRAIN) & (credits_q == '0));
      end
   end

endmodule

// File: tb/tb_l2_tcdm_burst_reader.sv
// tb_l2_tcdm_burst_reader: self-checking bench for l2_tcdm_burst_reader.
// A TCDM slave model grants with random stalls and answers one cycle after the grant;
// expected addresses and words are queued when a command is driven and popped as the
// DUT issues grants and delivers stream words.

module tb_l2_tcdm_burst_reader;

   localparam int DW    = 32;
   localparam int LW    = 16;
   localparam int DEPTH = 4;
`ifdef L2_BURST_READER_RANGE_CHECK_EN
   localparam int CHECK_EN = 1;
`else
   localparam int CHECK_EN = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [31:0]     cmd_addr = '0;
   logic [LW-1:0]   cmd_len = '0;
   logic            tcdm_req;
   logic [31:0]     tcdm_add;
   logic            tcdm_wen;
   logic [DW/8-1:0] tcdm_be;
   logic [DW-1:0]   tcdm_wdata;
   logic            tcdm_gnt = 1'b0;
   logic            tcdm_r_valid = 1'b0;
   logic [DW-1:0]   tcdm_r_rdata = '0;
   logic            data_valid;
   logic            data_ready = 1'b0;
   logic [DW-1:0]   data;
   logic            busy;
   logic            done;
   logic            err;

   l2_tcdm_burst_reader #(
      .DATA_WIDTH  (DW),
      .ADDR_STRIDE (4),
      .FIFO_DEPTH  (DEPTH),
      .LEN_WIDTH   (LW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_addr_i     (cmd_addr),
      .cmd_len_i      (cmd_len),
      .tcdm_req_o     (tcdm_req),
      .tcdm_add_o     (tcdm_add),
      .tcdm_wen_o     (tcdm_wen),
      .tcdm_be_o      (tcdm_be),
      .tcdm_wdata_o   (tcdm_wdata),
      .tcdm_gnt_i     (tcdm_gnt),
      .tcdm_r_valid_i (tcdm_r_valid),
      .tcdm_r_rdata_i (tcdm_r_rdata),
      .data_valid_o   (data_valid),
      .data_ready_i   (data_ready),
      .data_o         (data),
      .busy_o         (busy),
      .done_o         (done),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          len;
      int          stall;
      int          ready_mode;
      int          exp_grants;
      int          exp_done;
      int          exp_err;
      bit          chk_timing;
   } vec_t;

   vec_t        vecs [6];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] exp_addr_q [$];
   logic [31:0] exp_data_q [$];
   int          grants = 0;
   int          pops = 0;
   int          dones = 0;
   int          errs = 0;
   int          req_cycles = 0;
   int          first_valid_cyc = -1;
   int          last_pop_cyc = -1;
   int          accept_cyc = 0;
   int          stall_max = 0;
   int          stall_cnt = 0;
   int          ready_mode = 1;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_add = '0;
   bit          pend_valid = 1'b0;
   logic [31:0] pend_data = '0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Cycle counter used for latency and throughput measurements
   always @(posedge clk) cyc++;

   // TCDM slave model, stream consumer and event monitor, all evaluated mid-cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         tcdm_gnt     = 1'b0;
         tcdm_r_valid = 1'b0;
         pend_valid   = 1'b0;
         prev_wait    = 1'b0;
         stall_cnt    = 0;
      end else begin
         tcdm_r_valid = pend_valid;
         tcdm_r_rdata = pend_data;
         pend_valid   = 1'b0;
         if (prev_wait) begin
            check_output("req_hold", tcdm_req, 1);
            check_output("add_hold", tcdm_add, prev_add);
         end
         if (tcdm_req) begin
            req_cycles++;
            if (stall_cnt > 0) begin
               tcdm_gnt  = 1'b0;
               stall_cnt--;
               prev_wait = 1'b1;
               prev_add  = tcdm_add;
            end else begin
               tcdm_gnt  = 1'b1;
               prev_wait = 1'b0;
               grants++;
               if (exp_addr_q.size() == 0) begin
                  check_output("grant_expected", exp_addr_q.size(), 1);
               end else begin
                  check_output("tcdm_add", tcdm_add, exp_addr_q.pop_front());
               end
               pend_valid = 1'b1;
               pend_data  = word_of(tcdm_add);
               stall_cnt  = int'($urandom_range(stall_max, 0));
            end
         end else begin
            tcdm_gnt  = 1'b0;
            prev_wait = 1'b0;
         end
         case (ready_mode)
            0:       data_ready = 1'b0;
            1:       data_ready = 1'b1;
            default: data_ready = 1'($urandom_range(1, 0));
         endcase
         if (data_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
         end
         if (data_valid && data_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (exp_data_q.size() == 0) begin
               check_output("pop_expected", exp_data_q.size(), 1);
            end else begin
               check_output("stream_data", data, exp_data_q.pop_front());
            end
         end
         if (done) dones++;
         if (err) errs++;
      end
   end

   task automatic apply_stimulus(input logic [31:0] addr, input int len, input bit push_exp);
      grants          = 0;
      pops            = 0;
      dones           = 0;
      errs            = 0;
      req_cycles      = 0;
      first_valid_cyc = -1;
      last_pop_cyc    = -1;
      if (push_exp) begin
         for (int i = 0; i < len; i++) begin
            logic [31:0] a;
            a = addr + 32'(4 * i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(word_of(a));
         end
      end
      @(posedge clk); #1;
      check_output("cmd_ready_idle", cmd_ready, 1);
      cmd_valid  = 1'b1;
      cmd_addr   = addr;
      cmd_len    = LW'(len);
      accept_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid  = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while ((dones + errs) == 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("completion_seen", ((dones + errs) > 0), 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Global time limit in case a sequence stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main test sequence
   initial begin
      vecs[0] = '{32'h1C00_0000,  8, 0, 1, 8, 1, 0, 1'b1};
      vecs[1] = '{32'h1C01_0100, 12, 5, 2, 12, 1, 0, 1'b0};
      vecs[2] = '{32'h1C00_7FF0,  4, 2, 2, 4, 1, 0, 1'b0};
      vecs[3] = '{32'hFFFF_FFF8,  4, 0, 1, (CHECK_EN != 0) ? 0 : 4,
                  (CHECK_EN != 0) ? 0 : 1, (CHECK_EN != 0) ? 1 : 0, 1'b0};
      vecs[4] = '{32'h1C00_8000,  1, 3, 1, 1, 1, 0, 1'b0};
      vecs[5] = '{32'h1C02_0000, 20, 1, 2, 20, 1, 0, 1'b0};

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_cmd_ready", cmd_ready, 1);
      check_output("rst_req", tcdm_req, 0);
      check_output("rst_add", tcdm_add, 0);
      check_output("rst_data_valid", data_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      check_output("tcdm_wen", tcdm_wen, 1);
      check_output("tcdm_be", tcdm_be, 4'hF);
      check_output("tcdm_wdata", tcdm_wdata, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Table-driven bursts
      for (int i = 0; i < 6; i++) begin
         stall_max  = vecs[i].stall;
         ready_mode = vecs[i].ready_mode;
         apply_stimulus(vecs[i].addr, vecs[i].len, vecs[i].exp_err == 0);
         wait_done(600);
         check_output("vec_grants", grants, vecs[i].exp_grants);
         check_output("vec_pops", pops, vecs[i].exp_grants);
         check_output("vec_done", dones, vecs[i].exp_done);
         check_output("vec_err", errs, vecs[i].exp_err);
         check_output("vec_addr_left", exp_addr_q.size(), 0);
         check_output("vec_data_left", exp_data_q.size(), 0);
         check_output("vec_idle", busy, 0);
         if (vecs[i].chk_timing) begin
            check_output("first_data_latency", first_valid_cyc - accept_cyc, 3);
            check_output("throughput", last_pop_cyc - first_valid_cyc, vecs[i].len - 1);
         end
         exp_addr_q.delete();
         exp_data_q.delete();
      end

      // Stream blocked: only FIFO_DEPTH reads may be outstanding
      stall_max  = 0;
      ready_mode = 0;
      apply_stimulus(32'h1C00_0400, 10, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check_output("blocked_grants", grants, DEPTH);
      check_output("blocked_req", tcdm_req, 0);
      check_output("blocked_valid", data_valid, 1);
      check_output("blocked_busy", busy, 1);
      ready_mode = 1;
      wait_done(300);
      check_output("released_grants", grants, 10);
      check_output("released_pops", pops, 10);
      check_output("released_done", dones, 1);
      check_output("released_left", exp_data_q.size(), 0);

      // Zero-length command
      apply_stimulus(32'h1C00_0000, 0, 1'b1);
      check_output("len0_done_pulse", done, 1);
      check_output("len0_busy", busy, 0);
      @(posedge clk); #1;
      check_output("len0_done_end", done, 0);
      check_output("len0_no_req", req_cycles, 0);
      check_output("len0_done_count", dones, 1);

      // Reset while draining, then a normal command
      ready_mode = 0;
      apply_stimulus(32'h1C00_0100, 4, 1'b1);
      for (int n = 0; n < 50 && grants < 4; n++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check_output("drain_busy", busy, 1);
      check_output("drain_req", tcdm_req, 0);
      rst_n = 1'b0;
      #1;
      check_output("midrst_busy", busy, 0);
      check_output("midrst_req", tcdm_req, 0);
      check_output("midrst_valid", data_valid, 0);
      check_output("midrst_add", tcdm_add, 0);
      check_output("midrst_cmd_ready", cmd_ready, 1);
      check_output("midrst_done", done, 0);
      exp_addr_q.delete();
      exp_data_q.delete();
      @(posedge clk); #1;
      rst_n      = 1'b1;
      ready_mode = 1;
      stall_max  = 2;
      apply_stimulus(32'h1C00_0200, 6, 1'b1);
      wait_done(300);
      check_output("post_rst_grants", grants, 6);
      check_output("post_rst_pops", pops, 6);
      check_output("post_rst_done", dones, 1);
      check_output("post_rst_left", exp_data_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
